// File: rtl/fd_bank_ctrl_pkg.sv
// Shared definitions for the flop-bank controller: opcodes, FSM states and pulse-width limits.
package fd_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_PRESET = 2'b10,
        OP_LOAD   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        RECOV,
        SAMPLE,
        DONE
    } state_t;

    localparam int PW_MIN = 1;
    localparam int PW_MAX = 15;

    function automatic logic [1:0] selToOneHot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fd_bank_ctrl_if.sv
// Requester and flop-bank signal bundle; the controller takes the slave side.
interface fd_bank_ctrl_if
    import fd_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic [1:0]       req;
    op_t              op0;
    op_t              op1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] ff_d;
    logic             ff_clk;
    logic             ff_clr_n;
    logic             ff_set_n;
    logic [WIDTH-1:0] ff_q;

    modport slave (
        input  req, op0, op1, data0, data1, ff_q,
        output gnt, done, busy, rdata, ff_d, ff_clk, ff_clr_n, ff_set_n
    );

    modport master (
        output req, op0, op1, data0, data1, ff_q,
        input  gnt, done, busy, rdata, ff_d, ff_clk, ff_clr_n, ff_set_n
    );

endinterface

// File: rtl/fd_bank_ctrl_arb.sv
// Two-requester round-robin arbiter; priority flips to the loser on every accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_sel
);

    logic r_prio;

    // A lone requester always wins; on a tie the priority pointer decides.
    always_comb begin
        gnt_sel = r_prio;
        if (req == 2'b01) begin
            gnt_sel = 1'b0;
        end else if (req == 2'b10) begin
            gnt_sel = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (advance) begin
            r_prio <= ~gnt_sel;
        end
    end

endmodule

// File: rtl/fd_bank_ctrl.sv
// Sequences clear/preset/load/read operations onto an external flop bank for two requesters.
// Every output is a register loaded from the next-state logic, so outputs line up with the state.
module fd_bank_ctrl
    import fd_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = 3
) (
    input logic           clk,
    input logic           rst,
    fd_bank_ctrl_if.slave bus
);

    generate
        if (PW < PW_MIN || PW > PW_MAX) begin : g_pwCheck
            $error("fd_bank_ctrl: PW must lie within 1..15");
        end
    endgenerate

    localparam logic [3:0] PW_LOAD = 4'(PW - 1);

    state_t           r_state, w_stateNext;
    op_t              r_op, w_opNext;
    logic             r_sel, w_selNext;
    logic [3:0]       r_cnt, w_cntNext;
    logic [1:0]       r_gnt, w_gntNext;
    logic [1:0]       r_done, w_doneNext;
    logic             r_busy;
    logic [WIDTH-1:0] r_rdata, w_rdataNext;
    logic [WIDTH-1:0] r_ffD, w_ffDNext;
    logic             r_ffClk, w_ffClkNext;
    logic             r_ffClrN, w_ffClrNNext;
    logic             r_ffSetN, w_ffSetNNext;
    logic             w_winner;
    logic             w_advance;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req),
        .advance (w_advance),
        .gnt_sel (w_winner)
    );

    // Next state plus the output values that the next state must present.
    always_comb begin
        w_stateNext  = r_state;
        w_opNext     = r_op;
        w_selNext    = r_sel;
        w_cntNext    = r_cnt;
        w_gntNext    = 2'b00;
        w_doneNext   = 2'b00;
        w_rdataNext  = r_rdata;
        w_ffDNext    = r_ffD;
        w_ffClkNext  = 1'b0;
        w_ffClrNNext = 1'b1;
        w_ffSetNNext = 1'b1;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_advance = 1'b1;
                    w_selNext = w_winner;
                    w_opNext  = w_winner ? bus.op1 : bus.op0;
                    w_gntNext = selToOneHot(w_winner);
                    case (w_opNext)
                        OP_READ: w_stateNext = SAMPLE;
                        OP_LOAD: begin
                            w_stateNext = SETUP;
                            w_ffDNext   = w_winner ? bus.data1 : bus.data0;
                        end
                        default: begin
                            w_stateNext  = PULSE;
                            w_cntNext    = PW_LOAD;
                            w_ffClrNNext = (w_opNext != OP_CLEAR);
                            w_ffSetNNext = (w_opNext != OP_PRESET);
                        end
                    endcase
                end
            end
            SETUP: begin
                w_stateNext = PULSE;
                w_cntNext   = PW_LOAD;
                w_ffClkNext = 1'b1;
            end
            PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_stateNext = RECOV;
                end else begin
                    w_cntNext    = r_cnt - 4'd1;
                    w_ffClkNext  = (r_op == OP_LOAD);
                    w_ffClrNNext = (r_op != OP_CLEAR);
                    w_ffSetNNext = (r_op != OP_PRESET);
                end
            end
            RECOV: begin
                w_stateNext = DONE;
                w_doneNext  = selToOneHot(r_sel);
            end
            SAMPLE: begin
                w_stateNext = DONE;
                w_rdataNext = bus.ff_q;
                w_doneNext  = selToOneHot(r_sel);
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Reset holds the bank clear and aborts any operation without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_READ;
            r_sel    <= 1'b0;
            r_cnt    <= 4'd0;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_busy   <= 1'b0;
            r_rdata  <= '0;
            r_ffD    <= '0;
            r_ffClk  <= 1'b0;
            r_ffClrN <= 1'b0;
            r_ffSetN <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_op     <= w_opNext;
            r_sel    <= w_selNext;
            r_cnt    <= w_cntNext;
            r_gnt    <= w_gntNext;
            r_done   <= w_doneNext;
            r_busy   <= (w_stateNext != IDLE);
            r_rdata  <= w_rdataNext;
            r_ffD    <= w_ffDNext;
            r_ffClk  <= w_ffClkNext;
            r_ffClrN <= w_ffClrNNext;
            r_ffSetN <= w_ffSetNNext;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
    assign bus.rdata    = r_rdata;
    assign bus.ff_d     = r_ffD;
    assign bus.ff_clk   = r_ffClk;
    assign bus.ff_clr_n = r_ffClrN;
    assign bus.ff_set_n = r_ffSetN;

endmodule
